// File: rtl/serializer_lanes.sv
// serializer_lanes: parallel-to-serial converter with a one-word holding buffer.
// Each DIN_WIDTH word goes out as DIN_WIDTH/LANE_WIDTH beats of LANE_WIDTH bits.
// MSB_FIRST chooses which end of the word leaves first. A second word can be
// accepted while the first is still being sent, so words stream back to back.
// Optional feature: define SERIALIZER_LANES_PARITY_EN to append one even-parity
// beat after the data beats of every word.
module serializer_lanes #(
  parameter int DIN_WIDTH  = 32,
  parameter int LANE_WIDTH = 1,
  parameter int MSB_FIRST  = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic [DIN_WIDTH-1:0]  iv_din,
  input  logic                  i_din_valid,
  output logic                  o_ready,
  output logic [LANE_WIDTH-1:0] ov_dout,
  output logic                  o_dout_valid,
  input  logic                  i_ready,
  output logic                  o_last
);

  localparam int BEATS = DIN_WIDTH / LANE_WIDTH;
`ifdef SERIALIZER_LANES_PARITY_EN
  // The parity beat follows the data beats and becomes the final beat.
  localparam int FINAL_BEAT = BEATS;
`else
  localparam int FINAL_BEAT = BEATS - 1;
`endif
  localparam int CNT_W = (FINAL_BEAT < 1) ? 1 : $clog2(FINAL_BEAT + 1);
  localparam logic [CNT_W-1:0] FINAL_CNT = CNT_W'(FINAL_BEAT);

  if ((LANE_WIDTH > DIN_WIDTH) || (DIN_WIDTH % LANE_WIDTH != 0)) begin : g_bad_width
    $error("serializer_lanes: LANE_WIDTH (%0d) must divide DIN_WIDTH (%0d)",
           LANE_WIDTH, DIN_WIDTH);
  end

  logic [DIN_WIDTH-1:0]  sr;
  logic [DIN_WIDTH-1:0]  sr_shifted;
  logic [DIN_WIDTH-1:0]  hold;
  logic [DIN_WIDTH-1:0]  load_word;
  logic [CNT_W-1:0]      cnt;
  logic                  busy;
  logic                  hold_valid;
  logic                  in_xfer;
  logic                  out_xfer;
  logic                  final_beat;
  logic                  load;
  logic [LANE_WIDTH-1:0] lane;

  // Handshake qualifiers; ready depends only on registered state and control.
  assign o_ready      = i_en & ~i_rst & ~hold_valid;
  assign o_dout_valid = busy & i_en & ~i_rst;
  assign final_beat   = (cnt == FINAL_CNT);
  assign o_last       = o_dout_valid & final_beat;
  assign in_xfer      = i_din_valid & o_ready;
  assign out_xfer     = o_dout_valid & i_ready;

  // The output lane sits at the end of sr that leaves first; shift toward it.
  if (MSB_FIRST != 0) begin : g_msb_first
    assign lane       = sr[DIN_WIDTH-1 -: LANE_WIDTH];
    assign sr_shifted = sr << LANE_WIDTH;
  end else begin : g_lsb_first
    assign lane       = sr[LANE_WIDTH-1:0];
    assign sr_shifted = sr >> LANE_WIDTH;
  end

  // Select when and what to load into sr: the held word has priority, then a
  // word arriving on the same edge the final beat leaves, then a word into idle.
  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    load      = 1'b0;
    load_word = iv_din;
    if (out_xfer && final_beat) begin
      if (hold_valid) begin
        load      = 1'b1;
        load_word = hold;
      end else if (in_xfer) begin
        load = 1'b1;
      end
    end else if (in_xfer && !busy) begin
      load = 1'b1;
    end
  end

`ifdef SERIALIZER_LANES_PARITY_EN
  logic par;

  // Parity is taken from the whole word at the moment it enters sr.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      par <= 1'b0;
    end else if (i_en && load) begin
      par <= ^load_word;
    end
  end

  assign ov_dout = i_rst ? '0 : (final_beat ? LANE_WIDTH'(par) : lane);
`else
  assign ov_dout = i_rst ? '0 : lane;
`endif

  // Shift register, beat counter, holding buffer; everything freezes when i_en=0.
  always_ff @(posedge i_clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples values from before the edge, independent of statement order.
    if (i_rst) begin
      sr         <= '0;
      hold       <= '0;
      cnt        <= '0;
      busy       <= 1'b0;
      hold_valid <= 1'b0;
    end else if (i_en) begin
      if (load) begin
        sr   <= load_word;
        cnt  <= '0;
        busy <= 1'b1;
      end else if (out_xfer) begin
        if (final_beat) begin
          busy <= 1'b0;
        end else begin
          sr  <= sr_shifted;
          cnt <= cnt + 1'b1;
        end
      end

      if (out_xfer && final_beat && hold_valid) begin
        hold_valid <= 1'b0;
      end else if (in_xfer && busy && !(out_xfer && final_beat)) begin
        hold       <= iv_din;
        hold_valid <= 1'b1;
      end
    end
  end

endmodule
